serial_add_unit: RTL

//  Bit-serial adder. Operands are captured in parallel, then added LSB-first,
//  one bit per clock. Each bit uses a full-adder cell built from two halfAdder

---
 rtl/serial_add_unit_pkg.sv | 18 +
 rtl/serial_add_unit_if.sv | 16 +
 rtl/serial_add_unit_full_adder_cell.sv | 15 +
 rtl/serial_add_unit_half_adder.sv | 10 +
 rtl/serial_add_unit.sv | 96 +++++++++
 5 files changed

// File: rtl/serial_add_unit_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, width limit
// and the counter-width helper.
package serial_add_unit_pkg;

   localparam int WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A one-bit operand still needs a one-bit counter.
   function automatic int count_bits(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_add_unit_if.sv
// Request/result bundle of the bit-serial adder; the master drives operands,
// the slave (the adder) returns sum, carry and status.
interface serial_add_unit_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] SUM;
   logic             COUT;
   logic             busy;
   logic             done;

   modport master (output start, A, B, input SUM, COUT, busy, done);
   modport slave  (input start, A, B, output SUM, COUT, busy, done);
endinterface

// File: rtl/serial_add_unit_full_adder_cell.sv
// Full adder made of two half adders; the carries of both stages are ORed.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic s0, c0, c1;

   halfAdder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
   halfAdder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

   assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_unit_half_adder.sv
// Single-bit half adder: the basic cell the serial adder's full-adder is built from.
module halfAdder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial unsigned adder: captures A/B on start, adds one bit per clock
// LSB-first through a single full-adder cell, then pulses done with SUM/COUT.
module serial_add_unit
   import serial_add_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_add_unit_if.slave      bus
);
   localparam int CW = count_bits(WIDTH);

   if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_add_unit: WIDTH out of range 1..32");
   end

   state_t           state_reg;
   logic [WIDTH-1:0] op_a_reg, op_b_reg;
   logic [WIDTH-1:0] op_a_shift, op_b_shift;
   logic [WIDTH-1:0] sum_reg;
   logic [CW-1:0]    count_reg;
   logic             carry_reg, cout_reg, busy_reg, done_reg;
   logic             s_bit, c_bit, last_bit;

   full_adder_cell u_fa (
      .a    (op_a_reg[0]),
      .b    (op_b_reg[0]),
      .cin  (carry_reg),
      .s    (s_bit),
      .cout (c_bit)
   );

   // The A register doubles as the result register: each sum bit enters at
   // the MSB as the consumed operand bit leaves at the LSB.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_msb
         assign op_a_shift[gi] = s_bit;
         assign op_b_shift[gi] = 1'b0;
      end else begin : g_low
         assign op_a_shift[gi] = op_a_reg[gi+1];
         assign op_b_shift[gi] = op_b_reg[gi+1];
      end
   end

   assign last_bit = (count_reg == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         op_a_reg  <= '0;
         op_b_reg  <= '0;
         sum_reg   <= '0;
         count_reg <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  op_a_reg  <= bus.A;
                  op_b_reg  <= bus.B;
                  carry_reg <= 1'b0;
                  count_reg <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_RUN;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            ST_RUN: begin
               op_a_reg  <= op_a_shift;
               op_b_reg  <= op_b_shift;
               carry_reg <= c_bit;
               count_reg <= count_reg + CW'(1);
               if (last_bit) begin
                  sum_reg   <= op_a_shift;
                  cout_reg  <= c_bit;
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_DONE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.SUM  = sum_reg;
   assign bus.COUT = cout_reg;
   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
endmodule
